// File: rtl/dsp_32sub_serial_if.sv
// Word-serial subtractor stream bundle: operand words in, difference words out.
interface dsp_32sub_serial_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] AB;
    logic [31:0] CD;
    logic        borrowin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] O;
    logic        out_last;
    logic        borrowout;
    logic        out_zero;

    modport master (
        output in_valid, AB, CD, borrowin, out_ready,
        input  in_ready, out_valid, O, out_last, borrowout, out_zero
    );

    modport slave (
        input  in_valid, AB, CD, borrowin, out_ready,
        output in_ready, out_valid, O, out_last, borrowout, out_zero
    );
endinterface

// File: rtl/dsp_32sub_serial.sv
// Word-serial multi-precision subtractor, LS word first, borrow chained
// between words in a register. One output register, no skid buffer.
//
// state | meaning
// FIRST | next accepted word is word 0 (uses borrowin)
// MID   | next accepted word is word 1..WORDS-1 (uses borrow register)
module dsp_32sub_serial #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    dsp_32sub_serial_if.slave  bus
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {FIRST = 1'b0, MID = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              zacc_q, zacc_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [31:0]       o_q, o_d;

    logic              accept;
    logic              emit;
    logic              bin;
    logic              is_last;
    logic [32:0]       diff;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.O         = o_q;
    assign bus.out_last  = out_last_q;
    assign bus.borrowout = borrow_q;
    assign bus.out_zero  = zacc_q;

    // Datapath and next-state: handshake, borrow select, difference, counters.
    always_comb begin
        accept      = bus.in_valid && bus.in_ready;
        emit        = out_valid_q && bus.out_ready;
        bin         = (state_q == FIRST) ? bus.borrowin : borrow_q;
        is_last     = (idx_q == IDX_W'(WORDS - 1));
        // Bit 32 of the 33-bit result is set exactly when AB < CD + bin.
        diff        = {1'b0, bus.AB} - {1'b0, bus.CD} - {32'd0, bin};

        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        zacc_d      = zacc_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        o_d         = o_q;

        if (accept) begin
            o_d         = diff[31:0];
            borrow_d    = diff[32];
            out_last_d  = is_last;
            zacc_d      = ((state_q == FIRST) ? 1'b1 : zacc_q) && (diff[31:0] == 32'd0);
            idx_d       = is_last ? '0 : idx_q + IDX_W'(1);
            out_valid_d = 1'b1;
        end else if (emit) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FIRST: if (accept && (WORDS > 1)) state_d = MID;
            MID:   if (accept && is_last)     state_d = FIRST;
            default:                          state_d = FIRST;
        endcase
    end

    // State and data registers; reset wins over accept and emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FIRST;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            zacc_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            o_q         <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            zacc_q      <= zacc_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            o_q         <= o_d;
        end
    end
endmodule

// File: tb/tb_dsp_32sub_serial.sv
// Directed bench for dsp_32sub_serial: a WORDS=4 and a WORDS=2 instance.
module tb_dsp_32sub_serial;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dsp_32sub_serial_if bus4 ();
    dsp_32sub_serial_if bus2 ();

    dsp_32sub_serial #(.WORDS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    dsp_32sub_serial #(.WORDS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    // Sends one 4-word operand (word i driven at negedge, checked #1 after posedge).
    // Non-zero words drive the inverse of bin on borrowin to show it is ignored.
    task automatic send_op4(input string name, input logic [3:0][31:0] ab,
                            input logic [3:0][31:0] cd, input logic bin,
                            input logic [3:0][31:0] exp_o, input logic exp_b,
                            input logic exp_z);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus4.in_valid  = 1'b1;
            bus4.AB        = ab[i];
            bus4.CD        = cd[i];
            bus4.borrowin  = (i == 0) ? bin : ~bin;
            bus4.out_ready = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.O !== exp_o[i]) begin
                errors++;
                $display("FAIL %s word%0d: out_valid=%b O=%h, required 1 / %h", name, i, bus4.out_valid, bus4.O, exp_o[i]);
            end
            checks++;
            if (bus4.out_last !== (i == 3)) begin
                errors++;
                $display("FAIL %s out_last word%0d: got %b required %b", name, i, bus4.out_last, (i == 3));
            end
            if (i == 3) begin
                checks++;
                if (bus4.borrowout !== exp_b || bus4.out_zero !== exp_z) begin
                    errors++;
                    $display("FAIL %s final flags: borrowout=%b out_zero=%b, required %b %b", name, bus4.borrowout, bus4.out_zero, exp_b, exp_z);
                end
            end
        end
    endtask

    task automatic idle4();
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.borrowin = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus4.in_valid = 1'b0; bus4.AB = '0; bus4.CD = '0; bus4.borrowin = 1'b0; bus4.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.AB = '0; bus2.CD = '0; bus2.borrowin = 1'b0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.O !== 32'd0 ||
            bus4.out_last !== 1'b0 || bus4.borrowout !== 1'b0 || bus4.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset4: rdy=%b vld=%b O=%h last=%b bo=%b z=%b, required 1 0 0 0 0 0",
                     bus4.in_ready, bus4.out_valid, bus4.O, bus4.out_last, bus4.borrowout, bus4.out_zero);
        end
        checks++;
        if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus2.O !== 32'd0) begin
            errors++;
            $display("FAIL reset2: rdy=%b vld=%b O=%h, required 1 0 0", bus2.in_ready, bus2.out_valid, bus2.O);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_borrow_chain();
        send_op4("chain", {32'd0, 32'd0, 32'd0, 32'd1}, {32'd0, 32'd0, 32'd0, 32'd2}, 1'b0,
                 {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 1'b1, 1'b0);
        idle4();
        // Emit without accept: out_valid drops, data holds.
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.O !== 32'hFFFFFFFF || bus4.borrowout !== 1'b1) begin
            errors++;
            $display("FAIL emit_only: vld=%b O=%h bo=%b, required 0 ffffffff 1", bus4.out_valid, bus4.O, bus4.borrowout);
        end
    endtask

    task automatic test_equal();
        send_op4("equal", {4{32'h12345678}}, {4{32'h12345678}}, 1'b0, {4{32'd0}}, 1'b0, 1'b1);
        idle4();
    endtask

    task automatic test_back_to_back();
        send_op4("b2b_a", {4{32'd0}}, {32'd0, 32'd0, 32'd0, 32'd1}, 1'b0,
                 {4{32'hFFFFFFFF}}, 1'b1, 1'b0);
        send_op4("b2b_b", {32'd0, 32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd0, 32'd5}, 1'b0,
                 {4{32'd0}}, 1'b0, 1'b1);
        send_op4("b2b_c", {32'd0, 32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd0, 32'd5}, 1'b1,
                 {4{32'hFFFFFFFF}}, 1'b1, 1'b0);
        idle4();
    endtask

    task automatic test_backpressure();
        logic [3:0][31:0] ab  = {32'd40, 32'd30, 32'd20, 32'd10};
        logic [3:0][31:0] cd  = {32'd9, 32'd7, 32'd5, 32'd3};
        logic [3:0][31:0] exp = {32'd31, 32'd23, 32'd15, 32'd7};
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.AB = ab[0]; bus4.CD = cd[0]; bus4.borrowin = 1'b0;
        bus4.out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.O !== exp[0] || bus4.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: vld=%b O=%h rdy=%b, required 1 %h 0", bus4.out_valid, bus4.O, bus4.in_ready, exp[0]);
        end
        @(negedge clk);
        bus4.AB = ab[1]; bus4.CD = cd[1]; bus4.borrowin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.O !== exp[0] || bus4.in_ready !== 1'b0 || bus4.out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b O=%h rdy=%b last=%b, required 1 %h 0 0",
                         k, bus4.out_valid, bus4.O, bus4.in_ready, bus4.out_last, exp[0]);
            end
        end
        @(negedge clk);
        bus4.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if (i > 1) begin
                @(negedge clk);
                bus4.AB = ab[i]; bus4.CD = cd[i];
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.O !== exp[i] || bus4.out_last !== (i == 3)) begin
                errors++;
                $display("FAIL bp_word%0d: vld=%b O=%h last=%b, required 1 %h %b",
                         i, bus4.out_valid, bus4.O, bus4.out_last, exp[i], (i == 3));
            end
        end
        checks++;
        if (bus4.borrowout !== 1'b0 || bus4.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_flags: bo=%b z=%b, required 0 0", bus4.borrowout, bus4.out_zero);
        end
        idle4();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus4.in_valid = 1'b1; bus4.AB = 32'd1; bus4.CD = 32'd0; bus4.borrowin = 1'b0;
            bus4.out_ready = 1'b0;
        end
        @(posedge clk);
        // Reset while a word is offered and output pending: reset must win.
        @(negedge clk);
        reset = 1'b1;
        bus4.AB = 32'd999; bus4.CD = 32'd1; bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.O !== 32'd0 || bus4.borrowout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: vld=%b O=%h bo=%b, required 0 0 0", bus4.out_valid, bus4.O, bus4.borrowout);
        end
        @(negedge clk);
        reset = 1'b0;
        bus4.in_valid = 1'b0;
        send_op4("after_reset", {32'd0, 32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd0, 32'd3}, 1'b0,
                 {32'd0, 32'd0, 32'd0, 32'd2}, 1'b0, 1'b0);
        idle4();
    endtask

    task automatic test_words2();
        logic [1:0][31:0] ab  = {32'd1, 32'd0};
        logic [1:0][31:0] exp = {32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.AB = ab[i]; bus2.CD = 32'd0;
            bus2.borrowin = (i == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            checks++;
            if (bus2.out_valid !== 1'b1 || bus2.O !== exp[i] || bus2.out_last !== (i == 1)) begin
                errors++;
                $display("FAIL w2_word%0d: vld=%b O=%h last=%b, required 1 %h %b",
                         i, bus2.out_valid, bus2.O, bus2.out_last, exp[i], (i == 1));
            end
        end
        checks++;
        if (bus2.borrowout !== 1'b0 || bus2.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL w2_flags: bo=%b z=%b, required 0 0", bus2.borrowout, bus2.out_zero);
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_borrow_chain();
        test_equal();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_words2();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_32sub_serial.md
# dsp_32sub_serial

Word-serial multi-precision subtractor: streams an N-word operand pair (least-significant 32-bit word first) and returns the difference one word per accepted beat, propagating borrow between words in a register. It is the inverse-direction companion to the team's 32-bit DSP adder. It sits in the uncertainty-propagation datapath wherever wide fixed-point terms are differenced. The subtract core may map onto SB_MAC16 in subtract mode, with the output registered in fabric. Results must be bit-exact to the arithmetic defined below.

## Interface
- WORDS, 4: words per operand (total width 32*WORDS); legal range 1..16.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- in_valid  in  1  an input word is presented.
- in_ready  out  1  block can accept an input word this cycle.
- AB  in  32  minuend word.
- CD  in  32  subtrahend word.
- borrowin  in  1  initial borrow; sampled only on word 0 of an operand.
- out_valid  out  1  O holds a valid difference word.
- out_ready  in  1  downstream accepts O this cycle.
- O  out  32  difference word.
- out_last  out  1  O is the most-significant word of the operand.
- borrowout  out  1  final borrow; meaningful only when out_valid && out_last.
- out_zero  out  1  every word of the full difference is zero; meaningful only when out_valid && out_last.

## Operation
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- Word counter idx (width clog2(WORDS), minimum 1) tracks the position of the next accepted word. idx = 0 means the next word is the LS word.
- Per accepted word, compute {b, d} = {1'b0,AB} - {1'b0,CD} - bin:
  - bin = borrowin when idx = 0, otherwise the borrow register.
  - d is 32 bits. b = 1 iff AB < CD + bin (unsigned).
- On accept:
  - O <= d.
  - Borrow register <= b.
  - out_last <= (idx = WORDS-1).
  - zero accumulator zacc <= (idx = 0 ? 1 : zacc) && (d == 0).
  - idx <= (idx = WORDS-1) ? 0 : idx+1.
- borrowout presents the borrow register. out_zero presents zacc.
- States: FIRST (idx = 0) and MID (idx != 0).
  - FIRST -> MID on accept when WORDS > 1.
  - MID -> MID on accept while idx < WORDS-1.
  - MID -> FIRST on accept of word WORDS-1.
  - WORDS = 1: stays in FIRST permanently, and every word is last.
- Operands are unsigned. Signed callers interpret borrowout as the sign of the difference via their own overflow logic; this block does not do so.
- No framing input exists: word alignment is kept purely by counting. Only reset re-aligns the counter.

## Timing
- Reset values: in_ready = 1, out_valid = 0, O = 0, out_last = 0, borrowout = 0, out_zero = 0, idx = 0, borrow register = 0.
- Latency 1 cycle: a word accepted at edge k is on O with out_valid = 1 after edge k.
- in_ready = !out_valid || out_ready (combinational). This gives full throughput of 1 word/cycle with a single output register and no skid buffer.
- out_valid holds, and O, out_last, borrowout and out_zero hold stable, until Emit.
- Simultaneous Emit and Accept in one cycle: the new word replaces the old one and out_valid stays 1.
- Emit without Accept: out_valid <= 0 and the data registers hold their value.
- Stall mid-operand (in_valid low between words): the borrow register, idx and zacc hold indefinitely.
- reset asserted mid-operand: the partial operand is discarded, any pending output is dropped (out_valid = 0 on the next cycle), and the next accepted word is treated as word 0.
- reset takes priority over Accept and Emit in the same cycle.

## Test plan
- WORDS = 4; operands 0x...0001 - 0x...0002 (all upper words 0), borrowin = 0 -> O = FFFFFFFF, FFFFFFFF, FFFFFFFF, FFFFFFFF; borrowout = 1 on the last word; out_zero = 0.
- WORDS = 4; equal operands 0x12345678 in every word, borrowin = 0 -> all O = 0; out_last only on word 3; borrowout = 0; out_zero = 1.
- WORDS = 2; AB = {00000001, 00000000}, CD = {0, 0}, borrowin = 1 -> O = FFFFFFFF then 00000000; borrowout = 0; out_zero = 0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 after the first accept; O stable; no word lost or duplicated; the sequence completes correctly once out_ready = 1.
- Back-to-back operands at 1 word/cycle with out_ready = 1 -> borrow from operand N is never used by word 0 of operand N+1; that word uses its own borrowin.
- Assert reset after word 1 of 4, then send a fresh operand 5 - 3 -> out_valid = 0 in the cycle after reset; new result word 0 = 00000002; out_last lands on the 4th new word.
